branch_predictor: RTL and testbench

Parametrised branch target buffer with saturating-counter direction prediction for the five-stage pipeline. Fetch looks it up combinationally with the current PC and gets a predicted next PC. MEM feeds back resolved branches and jumps so the pipeline can redirect only on a misprediction, instead of always squashing on taken control flow. The block also has a cycle-by-cycle invalidate sweep and saturating statistics counters for performance evaluation.

---
 rtl/bpred_pkg.sv | 43 ++++
 rtl/bpred_sat_ctr.sv | 25 ++
 rtl/branch_predictor.sv | 155 +++++++++++++++
 tb/tb_branch_predictor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types and helpers for the branch predictor.
//   btb_entry_t    - one BTB entry {valid, tag, target[31:2], ctr}
//   bpred_state_t  - invalidate sweep state machine states
//   ctr_op_t       - operation selector for the saturating counter
//   ctr_weak_taken / ctr_strong_taken - counter constants for a given width
package bpred_pkg;

  // Widest direction counter an entry can hold; the top uses the low CTR_W bits.
  localparam int unsigned CTR_W_MAX = 8;

  // The tag field holds the full pc[31:2]. The index bits of an entry always
  // equal its array position, so a full compare matches a pc[31:IDX_W+2]
  // compare while keeping the struct independent of ENTRIES.
  typedef struct packed {
    logic                 valid;
    logic [29:0]          tag;
    logic [29:0]          target;
    logic [CTR_W_MAX-1:0] ctr;
  } btb_entry_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } bpred_state_t;

  typedef enum logic [1:0] {
    CTR_HOLD,
    CTR_INC,
    CTR_DEC,
    CTR_SET_MAX
  } ctr_op_t;

  // MSB set, rest clear.
  function automatic logic [CTR_W_MAX-1:0] ctr_weak_taken(input int unsigned w);
    return {{(CTR_W_MAX-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  // All ones in the low w bits.
  function automatic logic [CTR_W_MAX-1:0] ctr_strong_taken(input int unsigned w);
    return {CTR_W_MAX{1'b1}} >> (CTR_W_MAX - w);
  endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// bpred_sat_ctr: combinational next value of a saturating direction counter.
//   ctr_i  in  CTR_W  current counter value
//   op_i   in  op     hold / increment / decrement / set to all-ones
//   ctr_o  out CTR_W  next counter value, saturating at 0 and 2^CTR_W-1
module bpred_sat_ctr
  import bpred_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  ctr_op_t          op_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (op_i)
      CTR_INC:     if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
      CTR_DEC:     if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
      CTR_SET_MAX: ctr_o = '1;
      default:     ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: branch target buffer with saturating-counter direction
// prediction, an invalidate sweep and saturating statistics counters.
//   CLK, RST                  clock, synchronous active-high reset
//   f_valid, f_pc             fetch lookup qualifier and PC
//   pred_hit/taken/target     combinational prediction for f_pc
//   u_*                       branch/jump resolved in MEM (update port)
//   mispredict, recover_pc    combinational redirect request and PC
//   inv_req, busy             start invalidate sweep / sweep in progress
//   stat_*                    saturating lookup/hit/mispredict counters
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_valid,
  input  logic [31:0]       f_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              u_valid,
  input  logic              u_is_branch,
  input  logic [31:0]       u_pc,
  input  logic              u_taken,
  input  logic [31:0]       u_target,
  input  logic              u_pred_taken,
  input  logic [31:0]       u_pred_target,
  output logic              mispredict,
  output logic [31:0]       recover_pc,
  input  logic              inv_req,
  output logic              busy,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W_MAX-1:0] CTR_WEAK_TAKEN   = ctr_weak_taken(CTR_W);
  localparam logic [CTR_W_MAX-1:0] CTR_STRONG_TAKEN = ctr_strong_taken(CTR_W);

  btb_entry_t          btb_q [ENTRIES];
  bpred_state_t        state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [STAT_W-1:0]   stat_lookups_q, stat_hits_q, stat_mispredicts_q;

  logic [IDX_W-1:0]    f_idx, u_idx;
  logic                u_hit;
  logic                wr_en;
  btb_entry_t          wr_ent;
  ctr_op_t             ctr_op;
  logic [CTR_W-1:0]    ctr_nxt;

  assign busy  = (state_q == SWEEP);
  assign f_idx = f_pc[IDX_W+1:2];
  assign u_idx = u_pc[IDX_W+1:2];

  // Lookup
  assign pred_hit    = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_pc[31:2]) && !busy;
  assign pred_taken  = pred_hit && btb_q[f_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? {btb_q[f_idx].target, 2'b00} : f_pc + 32'd4;

  // Redirect
  assign mispredict = u_valid &&
                      ((u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target)));
  assign recover_pc = u_taken ? u_target : u_pc + 32'd4;

  bpred_sat_ctr #(
    .CTR_W (CTR_W)
  ) u_sat_ctr (
    .ctr_i (btb_q[u_idx].ctr[CTR_W-1:0]),
    .op_i  (ctr_op),
    .ctr_o (ctr_nxt)
  );

  // Update entry composition
  always_comb begin
    u_hit  = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_pc[31:2]);
    wr_en  = 1'b0;
    wr_ent = btb_q[u_idx];
    ctr_op = CTR_HOLD;
    if (u_valid && !busy) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (u_is_branch) begin
          ctr_op = u_taken ? CTR_INC : CTR_DEC;
          if (u_taken) wr_ent.target = u_target[31:2];
        end else begin
          ctr_op        = CTR_SET_MAX;
          wr_ent.target = u_target[31:2];
        end
        wr_ent.ctr = CTR_W_MAX'(ctr_nxt);
      end else if (u_taken || !u_is_branch) begin
        wr_en         = 1'b1;
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = u_pc[31:2];
        wr_ent.target = u_target[31:2];
        wr_ent.ctr    = u_is_branch ? CTR_WEAK_TAKEN : CTR_STRONG_TAKEN;
      end
    end
  end

  // Storage, sweep FSM and statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[IDX_W'(i)].valid <= 1'b0;
        btb_q[IDX_W'(i)].ctr   <= '0;
      end
      state_q            <= IDLE;
      ptr_q              <= '0;
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      // wr_en is never set while sweeping, so the two writes cannot collide.
      if (wr_en) btb_q[u_idx] <= wr_ent;

      unique case (state_q)
        IDLE: begin
          if (inv_req) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          btb_q[ptr_q].valid <= 1'b0;
          if (inv_req) begin
            ptr_q <= '0;
          end else if (ptr_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (f_valid && (stat_lookups_q != '1))
        stat_lookups_q <= stat_lookups_q + STAT_W'(1);
      if (f_valid && pred_hit && (stat_hits_q != '1))
        stat_hits_q <= stat_hits_q + STAT_W'(1);
      if (mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_hits        = stat_hits_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural BTB model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned STAT_W  = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              f_valid;
  logic [31:0]       f_pc;
  logic              pred_hit, pred_taken;
  logic [31:0]       pred_target;
  logic              u_valid, u_is_branch, u_taken, u_pred_taken;
  logic [31:0]       u_pc, u_target, u_pred_target;
  logic              mispredict;
  logic [31:0]       recover_pc;
  logic              inv_req, busy;
  logic [STAT_W-1:0] stat_lookups, stat_hits, stat_mispredicts;

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .STAT_W  (STAT_W)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .f_valid          (f_valid),
    .f_pc             (f_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .u_valid          (u_valid),
    .u_is_branch      (u_is_branch),
    .u_pc             (u_pc),
    .u_taken          (u_taken),
    .u_target         (u_target),
    .u_pred_taken     (u_pred_taken),
    .u_pred_target    (u_pred_target),
    .mispredict       (mispredict),
    .recover_pc       (recover_pc),
    .inv_req          (inv_req),
    .busy             (busy),
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: per-entry valid/tag/target/counter, a count of sweep
  // cycles still to run, and plain integer statistics.
  bit          mv   [ENTRIES];
  logic [31:0] mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mctr [ENTRIES];
  int          rem;
  int          m_lk, m_hit, m_mp;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_pred_hit();
    int unsigned i = idx_of(f_pc);
    return (rem == 0) && mv[i] && (mtag[i] == tag_of(f_pc));
  endfunction

  function automatic bit m_pred_taken();
    return m_pred_hit() && (mctr[idx_of(f_pc)] >= (1 << (CTR_W - 1)));
  endfunction

  function automatic logic [31:0] m_pred_target();
    return m_pred_taken() ? mtgt[idx_of(f_pc)] : f_pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    return u_valid && ((u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target)));
  endfunction

  task automatic model_edge();
    int unsigned ui;
    bit uhit;
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mv[i]   = 1'b0;
        mctr[i] = 0;
      end
      rem = 0; m_lk = 0; m_hit = 0; m_mp = 0;
      return;
    end
    if (f_valid && m_lk < STAT_MAX) m_lk++;
    if (f_valid && m_pred_hit() && m_hit < STAT_MAX) m_hit++;
    if (m_mispredict() && m_mp < STAT_MAX) m_mp++;
    ui   = idx_of(u_pc);
    uhit = mv[ui] && (mtag[ui] == tag_of(u_pc));
    if (u_valid && rem == 0) begin
      if (uhit && u_is_branch) begin
        if (u_taken) begin
          mctr[ui] = (mctr[ui] < CTR_MAX) ? mctr[ui] + 1 : CTR_MAX;
          mtgt[ui] = {u_target[31:2], 2'b00};
        end else begin
          mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
        end
      end else if (uhit) begin
        mctr[ui] = CTR_MAX;
        mtgt[ui] = {u_target[31:2], 2'b00};
      end else if (u_taken || !u_is_branch) begin
        mv[ui]   = 1'b1;
        mtag[ui] = tag_of(u_pc);
        mtgt[ui] = {u_target[31:2], 2'b00};
        mctr[ui] = u_is_branch ? (1 << (CTR_W - 1)) : CTR_MAX;
      end
    end
    if (rem > 0) begin
      mv[ENTRIES - rem] = 1'b0;
      rem = inv_req ? ENTRIES : rem - 1;
    end else if (inv_req) begin
      rem = ENTRIES;
    end
  endtask

  // Compare every output with the model, then advance one clock.
  task automatic tick();
    #1;
    check("busy",        32'(busy),             32'(rem > 0));
    check("pred_hit",    32'(pred_hit),         32'(m_pred_hit()));
    check("pred_taken",  32'(pred_taken),       32'(m_pred_taken()));
    check("pred_target", pred_target,           m_pred_target());
    check("mispredict",  32'(mispredict),       32'(m_mispredict()));
    check("recover_pc",  recover_pc,            u_taken ? u_target : u_pc + 32'd4);
    check("stat_lk",     32'(stat_lookups),     32'(m_lk));
    check("stat_hit",    32'(stat_hits),        32'(m_hit));
    check("stat_mp",     32'(stat_mispredicts), 32'(m_mp));
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic drive_idle();
    RST = 1'b0; f_valid = 1'b0; f_pc = 32'h0; inv_req = 1'b0;
    u_valid = 1'b0; u_is_branch = 1'b0; u_pc = 32'h0; u_taken = 1'b0;
    u_target = 32'h0; u_pred_taken = 1'b0; u_pred_target = 32'h0;
  endtask

  task automatic drive_update(input logic br, input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic ptk);
    drive_idle();
    u_valid = 1'b1; u_is_branch = br; u_pc = pc; u_taken = tk;
    u_target = tgt; u_pred_taken = ptk; u_pred_target = 32'h0;
  endtask

  task automatic drive_lookup(input logic [31:0] pc);
    drive_idle();
    f_valid = 1'b1; f_pc = pc;
  endtask

  int n;

  initial begin
    rem = 0; m_lk = 0; m_hit = 0; m_mp = 0;
    drive_idle();
    RST = 1'b1;
    @(negedge CLK);
    tick(); tick();

    // Reset state
    drive_lookup(32'h40);
    #1;
    check("rst_hit",    32'(pred_hit),     32'h0);
    check("rst_target", pred_target,       32'h44);
    check("rst_stats",  32'(stat_lookups), 32'h0);
    tick();

    // Allocate a taken branch
    drive_update(1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    #1;
    check("alloc_mp",  32'(mispredict), 32'h1);
    check("alloc_rec", recover_pc,      32'h100);
    tick();
    drive_lookup(32'h40);
    #1;
    check("alloc_hit",   32'(pred_hit),   32'h1);
    check("alloc_taken", 32'(pred_taken), 32'h1);
    check("alloc_tgt",   pred_target,     32'h100);
    tick();

    // Walk the counter down and check it saturates at zero
    drive_update(1'b1, 32'h40, 1'b0, 32'h100, 1'b1); tick();
    drive_update(1'b1, 32'h40, 1'b0, 32'h100, 1'b1); tick();
    drive_lookup(32'h40);
    #1;
    check("nt_hit",   32'(pred_hit),   32'h1);
    check("nt_taken", 32'(pred_taken), 32'h0);
    check("nt_tgt",   pred_target,     32'h44);
    tick();
    drive_update(1'b1, 32'h40, 1'b0, 32'h100, 1'b0); tick();
    drive_lookup(32'h40);
    #1;
    check("sat0_taken", 32'(pred_taken), 32'h0);
    tick();
    drive_update(1'b1, 32'h40, 1'b1, 32'h100, 1'b0); tick();
    drive_lookup(32'h40);
    #1;
    check("sat0_inc_taken", 32'(pred_taken), 32'h0);
    tick();

    // Aliasing on index 0
    drive_update(1'b1, 32'h80, 1'b1, 32'h200, 1'b0); tick();
    drive_lookup(32'h40);
    #1;
    check("alias_miss", 32'(pred_hit), 32'h0);
    tick();
    drive_lookup(32'h80);
    #1;
    check("alias_tgt", pred_target, 32'h200);
    tick();

    // Sweep with four valid entries and a dropped mid-sweep update
    for (int k = 0; k < 4; k++) begin
      drive_update(1'b0, 32'h1000 + 32'(4 * k), 1'b1, 32'h3000 + 32'(16 * k), 1'b1);
      tick();
    end
    drive_lookup(32'h1004);
    #1;
    check("jmp_tgt", pred_target, 32'h3010);
    tick();
    drive_idle(); inv_req = 1'b1; tick();
    n = 0;
    while (busy && n < 100) begin
      n++;
      drive_idle();
      if (n == 3) drive_update(1'b0, 32'h2000, 1'b1, 32'h5000, 1'b0);
      tick();
    end
    check("sweep_len", 32'(n), 32'd16);
    for (int k = 0; k < 5; k++) begin
      drive_lookup((k == 4) ? 32'h2000 : 32'h1000 + 32'(4 * k));
      #1;
      check("post_sweep_miss", 32'(pred_hit), 32'h0);
      tick();
    end

    // Restarted sweep
    drive_update(1'b0, 32'h1000, 1'b1, 32'h3000, 1'b1); tick();
    drive_idle(); inv_req = 1'b1; tick();
    n = 0;
    while (busy && n < 100) begin
      n++;
      drive_idle();
      inv_req = (n == 5);
      tick();
    end
    check("restart_len", 32'(n), 32'd21);

    // Statistics saturation, then reset mid-sweep
    drive_idle(); RST = 1'b1; tick();
    for (int k = 0; k < 20; k++) begin
      drive_lookup(32'h40 + 32'(4 * k));
      tick();
    end
    drive_idle();
    #1;
    check("stat_sat", 32'(stat_lookups), 32'd15);
    tick();
    drive_idle(); inv_req = 1'b1; f_valid = 1'b1; tick();
    drive_idle(); f_valid = 1'b1; tick(); tick(); tick();
    drive_idle(); RST = 1'b1; tick();
    drive_idle();
    #1;
    check("rst_busy",    32'(busy),         32'h0);
    check("rst_lookups", 32'(stat_lookups), 32'h0);
    tick();

    // Randomized traffic over a small PC pool so entries hit and alias
    for (int c = 0; c < 3000; c++) begin
      drive_idle();
      RST         = ($urandom_range(0, 99) == 0);
      inv_req     = ($urandom_range(0, 59) == 0);
      f_valid     = ($urandom_range(0, 9) < 7);
      f_pc        = 32'h400 + 32'($urandom_range(0, 2) << 6) + 32'($urandom_range(0, 15) << 2);
      u_valid     = $urandom_range(0, 1) == 1;
      u_is_branch = $urandom_range(0, 3) != 0;
      u_pc        = 32'h400 + 32'($urandom_range(0, 2) << 6) + 32'($urandom_range(0, 15) << 2);
      u_taken     = u_is_branch ? ($urandom_range(0, 1) == 1) : 1'b1;
      u_target    = $urandom & 32'hFFFF_FFFC;
      u_pred_taken  = $urandom_range(0, 1) == 1;
      u_pred_target = ($urandom_range(0, 1) == 1) ? u_target : ($urandom & 32'hFFFF_FFFC);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
